// File: rtl/seq_mult_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// The master issues start with operands; the slave reports busy/done and the product.
interface seq_mult_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     m;
    logic [WIDTH-1:0]     q;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   p;

    modport master (
        output start, signed_mode, m, q,
        input  busy, done, p
    );

    modport slave (
        input  start, signed_mode, m, q,
        output busy, done, p
    );
endinterface

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one conditional add per cycle on operand
// magnitudes, with the sign reapplied to the 2*WIDTH-bit product at completion.
module seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    seq_mult_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     m_reg, m_next;
    logic [WIDTH-1:0]     q_reg, q_next;
    logic [WIDTH-1:0]     acc_reg, acc_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 neg_reg, neg_next;
    logic                 done_reg, done_next;
    logic [2*WIDTH-1:0]   p_reg, p_next;

    logic [WIDTH-1:0]     m_mag, q_mag, addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod;

    // Multiplicand gated by the multiplier LSB forms this cycle's partial product.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = m_reg[gi] & q_reg[0];
        end
    endgenerate

    assign sum  = {1'b0, acc_reg} + {1'b0, addend};
    // The vacated multiplier bits collect the low half of the product as it shifts.
    assign prod = {sum[WIDTH:1], sum[0], q_reg[WIDTH-1:1]};

    always_comb begin
        m_mag = bus.m;
        q_mag = bus.q;
        if (bus.signed_mode && bus.m[WIDTH-1]) m_mag = -bus.m;
        if (bus.signed_mode && bus.q[WIDTH-1]) q_mag = -bus.q;
    end

    always_comb begin
        state_next = state_reg;
        m_next     = m_reg;
        q_next     = q_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        neg_next   = neg_reg;
        done_next  = 1'b0;
        p_next     = p_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    m_next     = m_mag;
                    q_next     = q_mag;
                    neg_next   = bus.signed_mode & (bus.m[WIDTH-1] ^ bus.q[WIDTH-1]);
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                acc_next = sum[WIDTH:1];
                q_next   = {sum[0], q_reg[WIDTH-1:1]};
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH-1)) begin
                    p_next     = neg_reg ? -prod : prod;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            m_reg     <= '0;
            q_reg     <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            neg_reg   <= 1'b0;
            done_reg  <= 1'b0;
            p_reg     <= '0;
        end else begin
            state_reg <= state_next;
            m_reg     <= m_next;
            q_reg     <= q_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            neg_reg   <= neg_next;
            done_reg  <= done_next;
            p_reg     <= p_next;
        end
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.done = done_reg;
    assign bus.p    = p_reg;
endmodule

// File: tb/tb_seq_mult.sv
// Directed and randomised checks of seq_mult at WIDTH=4 and WIDTH=8 against
// an arithmetic reference product.
module tb_seq_mult;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   starts4 = 0, dones4 = 0, starts8 = 0, dones8 = 0;

    always #5 clk = ~clk;

    seq_mult_if #(.WIDTH(4)) bus4 ();
    seq_mult_if #(.WIDTH(8)) bus8 ();

    seq_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    seq_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret operands per mode, multiply as integers, keep 2*w bits.
    function automatic logic [15:0] ref_prod(input int w, input bit sm, input int a, input int b);
        int ai = a;
        int bi = b;
        int r;
        if (sm && a >= (1 << (w - 1))) ai = a - (1 << w);
        if (sm && b >= (1 << (w - 1))) bi = b - (1 << w);
        r = (ai * bi) & ((1 << (2 * w)) - 1);
        return r[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run4(input bit sm, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        int cyc = 0;
        bit busy_ok = 1'b1;
        @(negedge clk);
        bus4.start = 1'b1; bus4.signed_mode = sm; bus4.m = a; bus4.q = b;
        step();
        starts4++;
        bus4.start = 1'b0; bus4.signed_mode = 1'($urandom); bus4.m = 4'($urandom); bus4.q = 4'($urandom);
        while (!bus4.done && cyc < 20) begin
            if (bus4.busy !== 1'b1) busy_ok = 1'b0;
            step();
            cyc++;
        end
        if (bus4.done) dones4++;
        $display("w4 sm=%0d m=%h q=%h p=%h exp=%h lat=%0d", sm, a, b, bus4.p, exp, cyc);
        chk("w4_latency", cyc, 4);
        chk("w4_product", bus4.p, exp);
        chk("w4_busy_run", busy_ok, 1'b1);
        chk("w4_busy_at_done", bus4.busy, 1'b0);
        step();
        chk("w4_done_pulse", bus4.done, 1'b0);
        chk("w4_p_hold", bus4.p, exp);
    endtask

    task automatic run8(input bit sm, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int cyc = 0;
        bit busy_ok = 1'b1;
        @(negedge clk);
        bus8.start = 1'b1; bus8.signed_mode = sm; bus8.m = a; bus8.q = b;
        step();
        starts8++;
        bus8.start = 1'b0; bus8.signed_mode = 1'($urandom); bus8.m = 8'($urandom); bus8.q = 8'($urandom);
        while (!bus8.done && cyc < 30) begin
            if (bus8.busy !== 1'b1) busy_ok = 1'b0;
            step();
            cyc++;
        end
        if (bus8.done) dones8++;
        $display("w8 sm=%0d m=%h q=%h p=%h exp=%h lat=%0d", sm, a, b, bus8.p, exp, cyc);
        chk("w8_latency", cyc, 8);
        chk("w8_product", bus8.p, exp);
        chk("w8_busy_run", busy_ok, 1'b1);
        chk("w8_busy_at_done", bus8.busy, 1'b0);
        step();
        chk("w8_done_pulse", bus8.done, 1'b0);
        chk("w8_p_hold", bus8.p, exp);
    endtask

    initial begin
        int cyc;
        int ndone;
        logic [15:0] e;
        logic [7:0]  ra, rb;
        bit          rs;

        rst = 1'b1;
        bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.m = '0; bus4.q = '0;
        bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.m = '0; bus8.q = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy4", bus4.busy, 1'b0);
        chk("rst_done4", bus4.done, 1'b0);
        chk("rst_p4", bus4.p, 8'h00);
        chk("rst_busy8", bus8.busy, 1'b0);
        chk("rst_p8", bus8.p, 16'h0000);

        // Directed products with hand-derived expectations.
        run4(1'b0, 4'hF, 4'hF, 8'hE1);
        run4(1'b1, 4'h8, 4'h8, 8'h40);
        run4(1'b1, 4'h8, 4'h7, 8'hC8);
        run4(1'b1, 4'h3, 4'hB, 8'hF1);
        run4(1'b1, 4'h0, 4'hF, 8'h00);
        run8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run8(1'b1, 8'h80, 8'h80, 16'h4000);

        // Start held high: second operation is accepted in the done cycle.
        @(negedge clk);
        bus4.start = 1'b1; bus4.signed_mode = 1'b0; bus4.m = 4'd2; bus4.q = 4'd3;
        step();
        starts4++;
        bus4.m = 4'd5; bus4.q = 4'd6;
        cyc = 0;
        while (!bus4.done && cyc < 20) begin step(); cyc++; end
        if (bus4.done) dones4++;
        $display("b2b first p=%h lat=%0d", bus4.p, cyc);
        chk("b2b_lat1", cyc, 4);
        chk("b2b_p1", bus4.p, 8'd6);
        step();
        starts4++;
        chk("b2b_busy2", bus4.busy, 1'b1);
        chk("b2b_p1_hold", bus4.p, 8'd6);
        cyc = 0;
        while (!bus4.done && cyc < 20) begin
            bus4.start = 1'(cyc);
            bus4.m = 4'($urandom); bus4.q = 4'($urandom); bus4.signed_mode = 1'($urandom);
            step();
            cyc++;
        end
        bus4.start = 1'b0;
        if (bus4.done) dones4++;
        $display("b2b second p=%h lat=%0d", bus4.p, cyc);
        chk("b2b_lat2", cyc, 4);
        chk("b2b_p2", bus4.p, 8'd30);
        step();
        chk("b2b_idle_after", bus4.busy, 1'b0);

        // Reset at the second edge of a run aborts it silently.
        @(negedge clk);
        bus4.start = 1'b1; bus4.signed_mode = 1'b0; bus4.m = 4'd9; bus4.q = 4'd9;
        step();
        bus4.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("reset mid-op busy=%b done=%b p=%h", bus4.busy, bus4.done, bus4.p);
        chk("abort_busy", bus4.busy, 1'b0);
        chk("abort_done", bus4.done, 1'b0);
        chk("abort_p", bus4.p, 8'h00);
        ndone = 0;
        repeat (8) begin step(); if (bus4.done) ndone++; end
        chk("abort_no_done", ndone, 0);

        // Exhaustive WIDTH=4 sweep in both modes.
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    e = ref_prod(4, s[0], a, b);
                    run4(s[0], a[3:0], b[3:0], e[7:0]);
                end

        // Random WIDTH=8 sweep.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            e  = ref_prod(8, rs, int'(ra), int'(rb));
            run8(rs, ra, rb, e);
        end

        chk("done_count4", dones4, starts4);
        chk("done_count8", dones8, starts8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
